shift_engine: RTL and testbench
===============================

Name: shift_engine

Overview:
- Parameterised serial shift engine. It is the successor of the single-width, LSB-only shift register used in the UART transmitter.
- Adds a load handshake, a per-transfer bit length, and per-transfer bit order (LSB- or MSB-first).
- Adds a simultaneous serial-in capture path, so the same block serves both the Tx and Rx datapaths.
- Sits between the UART controller FSM (which supplies `load_valid_i` and the baud-tick `shift_i`) and the line pin or synchroniser.

Parameters:
- DW, 8: maximum word width in bits; legal range 2..32.
- CW, $clog2(DW+1): width of the length field and the internal bit counter.
- IDLE_LEVEL, 1'b1: value driven on `serial_o` whenever no transfer is active (UART mark level).

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous and active-high.
- data_i  input  DW  parallel word to serialise; sampled on load accept.
- len_i  input  CW  number of bits in the transfer; sampled on load accept. Values 0 or >DW are treated as DW.
- msb_first_i  input  1  bit order; sampled on load accept. 1 = bit len-1 first, 0 = bit 0 first.
- load_valid_i  input  1  request to start a transfer.
- load_ready_o  output  1  block can accept a load; high only in IDLE.
- shift_i  input  1  single-cycle strobe that advances one bit.
- serial_i  input  1  serial input bit; sampled on each accepted `shift_i`.
- serial_o  output  1  current serial output bit.
- busy_o  output  1  transfer in progress (SHIFT state).
- done_o  output  1  one-cycle pulse when the last bit has been shifted.
- rx_data_o  output  DW  word assembled from `serial_i`; updated only at done.

Behaviour:
- Reset (`rst_i` = 1 at a clock edge):
  - State goes to IDLE.
  - `load_ready_o` = 1, `busy_o` = 0, `done_o` = 0.
  - `serial_o` = IDLE_LEVEL, `rx_data_o` = 0.
  - Internal data, capture and counter registers are cleared.
  - Reset wins over every other input, including mid-transfer. The partial transfer is discarded, no done pulse is generated, and `rx_data_o` is reset to 0.
- States: IDLE, SHIFT. All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.
- IDLE:
  - `load_ready_o` = 1 and `serial_o` = IDLE_LEVEL.
  - `shift_i` is ignored.
  - Load accept is `load_valid_i` & `load_ready_o`. On accept:
    - Latch `data_i`, the effective length L (1..DW) and `msb_first_i`.
    - Clear the capture register and set bit counter k = 0.
    - Next state is SHIFT.
  - Latency: the first bit appears on `serial_o` in the cycle after accept, and `busy_o` rises in the same cycle.
- SHIFT:
  - `load_ready_o` = 0, so `load_valid_i` is ignored and never queued.
  - `serial_o` = data_q[idx], where idx = k when LSB-first and idx = L-1-k when MSB-first.
  - On `shift_i` = 1:
    - Write the sampled `serial_i` into capture[idx], using the same idx.
    - k increments.
  - If k was L-1 when `shift_i` fired:
    - Next state is IDLE and `done_o` pulses for exactly one cycle.
    - `rx_data_o` takes the full capture word, with the final bit included. Bits L..DW-1 are 0.
    - `serial_o` returns to IDLE_LEVEL in the same cycle that `done_o` is high.
  - Without `shift_i`, all state holds. There is no timeout.
- Back-to-back transfers:
  - A load may be accepted in the cycle `done_o` is high, because state is IDLE in that cycle.
  - Minimum spacing between transfers is therefore one idle cycle.
- Held outputs: `rx_data_o` holds its value between done pulses; `data_q` is never modified by shifting (index-based, non-destructive).
- Counter width: k never exceeds L-1 ≤ DW-1. The comparison uses CW bits, and there is no wrap-around.
- L = 1 is legal: one `shift_i` completes the transfer.

Test Plan:
- Reset: hold `rst_i` for 2 cycles with `load_valid_i` = 1 → `serial_o` = 1, `load_ready_o` = 1, `busy_o` = 0, `rx_data_o` = 0, and no load accepted during reset.
- LSB-first: `data_i` = 8'hA5, `len_i` = 8, `msb_first_i` = 0, 8 strobes spaced 4 cycles apart.
  - Required: `serial_o` sequence 1,0,1,0,0,1,0,1.
  - Required: `done_o` high for 1 cycle after the 8th strobe, then `serial_o` = 1 and `load_ready_o` = 1.
- MSB-first with loopback (`serial_i` = `serial_o`): `data_i` = 8'h3C, `len_i` = 8, `msb_first_i` = 1.
  - Required: sequence 0,0,1,1,1,1,0,0.
  - Required: `rx_data_o` = 8'h3C at done.
- Short length: `data_i` = 8'hFF, `len_i` = 5, LSB-first, `serial_i` driving 1,0,1,1,0.
  - Required: exactly 5 bits of 1 on `serial_o`, done after the 5th strobe.
  - Required: `rx_data_o` = 8'h0D.
- Length boundaries:
  - `len_i` = 0 → a 9th strobe is never needed; done comes after the 8th.
  - `len_i` = 1 → done comes after 1 strobe.
- Simultaneous events:
  - `load_valid_i` with new data during SHIFT → ignored; the original transfer completes unchanged.
  - Load and `shift_i` in the same IDLE cycle → load accepted, shift ignored, and the first bit is not skipped.
  - `rst_i` after 3 of 8 bits → IDLE next cycle, no `done_o`, `rx_data_o` = 0.

Source files
------------

// File: rtl/shift_engine_if.sv
// Load/shift/serial bundle between the UART controller and shift_engine.
// The controller drives through master; the engine attaches as slave.
interface shift_engine_if #(
    parameter int DW = 8,
    parameter int CW = $clog2(DW + 1)
);
    logic [DW-1:0] data_i;
    logic [CW-1:0] len_i;
    logic          msb_first_i;
    logic          load_valid_i;
    logic          load_ready_o;
    logic          shift_i;
    logic          serial_i;
    logic          serial_o;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] rx_data_o;

    modport slave (
        input  data_i, len_i, msb_first_i, load_valid_i, shift_i, serial_i,
        output load_ready_o, serial_o, busy_o, done_o, rx_data_o
    );

    modport master (
        output data_i, len_i, msb_first_i, load_valid_i, shift_i, serial_i,
        input  load_ready_o, serial_o, busy_o, done_o, rx_data_o
    );
endinterface

// File: rtl/shift_engine.sv
// Serial shift engine: serialises a latched word LSB/MSB-first while capturing serial_i.
// Latency: first bit on serial_o the cycle after load accept; done_o the cycle after the last strobe.
// Backpressure: load_ready_o is low for the whole transfer; loads offered meanwhile are dropped, not queued.
module shift_engine #(
    parameter int   DW         = 8,
    parameter int   CW         = $clog2(DW + 1),
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    shift_engine_if.slave  bus
);
    localparam int IW = $clog2(DW);

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] len;
        logic          msb;
    } xfer_t;

    state_t        state_q, state_d;
    xfer_t         xfer_q, xfer_d;
    logic [DW-1:0] cap_q, cap_d;
    logic [DW-1:0] rx_q, rx_d;
    logic [CW-1:0] k_q, k_d;
    logic          done_q, done_d;

    logic [CW-1:0] len_eff;
    logic [IW-1:0] idx;

    // Out-of-range lengths (0 or above DW) collapse to a full-width transfer.
    assign len_eff = (bus.len_i == '0 || bus.len_i > CW'(DW)) ? CW'(DW) : bus.len_i;

    // Same index drives serial_o and the capture write, so Tx and Rx stay bit-aligned.
    assign idx = xfer_q.msb ? IW'(xfer_q.len - CW'(1) - k_q) : IW'(k_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            xfer_q  <= '0;
            cap_q   <= '0;
            rx_q    <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xfer_q  <= xfer_d;
            cap_q   <= cap_d;
            rx_q    <= rx_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xfer_d  = xfer_q;
        cap_d   = cap_q;
        rx_d    = rx_q;
        k_d     = k_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_valid_i) begin
                    xfer_d.data = bus.data_i;
                    xfer_d.len  = len_eff;
                    xfer_d.msb  = bus.msb_first_i;
                    cap_d       = '0;
                    k_d         = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_i) begin
                    cap_d[idx] = bus.serial_i;
                    k_d        = k_q + CW'(1);
                    if (k_q == xfer_q.len - CW'(1)) begin
                        rx_d    = cap_d;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.load_ready_o = (state_q == IDLE);
    assign bus.busy_o       = (state_q == SHIFT);
    assign bus.done_o       = done_q;
    assign bus.rx_data_o    = rx_q;
    assign bus.serial_o     = (state_q == SHIFT) ? xfer_q.data[idx] : IDLE_LEVEL;
endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine: expected serial bits and rx words are queued at load
// and popped as the engine shifts them out.
module tb_shift_engine;
    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_engine_if #(.DW(DW), .CW(CW)) bus ();

    shift_engine #(.DW(DW), .CW(CW), .IDLE_LEVEL(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic          exp_ser[$];
    logic [DW-1:0] exp_rx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input logic [DW-1:0] data, input int len, input bit msb,
                            input logic [DW-1:0] sin_w, input bit loopback, input int gap,
                            input bit noise, input bit shift_at_load, input int abort_at,
                            input bit b2b);
        int L;
        int idx;
        logic [DW-1:0] rx;
        logic [DW-1:0] r;
        logic b;
        L  = (len == 0 || len > DW) ? DW : len;
        rx = '0;
        for (int k = 0; k < L; k++) begin
            idx = msb ? (L - 1 - k) : k;
            exp_ser.push_back(data[idx]);
            rx[idx] = loopback ? data[idx] : sin_w[k];
        end
        exp_rx.push_back(rx);

        chk("ready_before_load", bus.load_ready_o, 1);
        bus.data_i       = data;
        bus.len_i        = CW'(len);
        bus.msb_first_i  = msb;
        bus.load_valid_i = 1'b1;
        bus.shift_i      = shift_at_load;
        bus.serial_i     = 1'b1;
        tick();
        bus.load_valid_i = 1'b0;
        bus.shift_i      = 1'b0;
        chk("busy_after_load", bus.busy_o, 1);
        chk("ready_in_shift", bus.load_ready_o, 0);

        for (int k = 0; k < L; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_busy", bus.busy_o, 0);
                chk("abort_ready", bus.load_ready_o, 1);
                chk("abort_done", bus.done_o, 0);
                chk("abort_serial", bus.serial_o, 1);
                chk("abort_rx", bus.rx_data_o, 0);
                exp_ser.delete();
                exp_rx.delete();
                tick();
                chk("abort_no_late_done", bus.done_o, 0);
                return;
            end
            b = exp_ser.pop_front();
            chk("serial_bit", bus.serial_o, b);
            bus.serial_i = loopback ? bus.serial_o : sin_w[k];
            bus.shift_i  = 1'b1;
            tick();
            bus.shift_i  = 1'b0;
            if (k < L - 1) begin
                chk("done_early", bus.done_o, 0);
                for (int g = 0; g < gap; g++) begin
                    bus.load_valid_i = noise;
                    bus.data_i       = ~data;
                    bus.msb_first_i  = ~msb;
                    bus.len_i        = CW'(1);
                    tick();
                    chk("serial_hold", bus.serial_o, exp_ser[0]);
                    chk("busy_hold", bus.busy_o, 1);
                end
                bus.load_valid_i = 1'b0;
            end
        end

        r = exp_rx.pop_front();
        chk("done_pulse", bus.done_o, 1);
        chk("serial_idle_at_done", bus.serial_o, 1);
        chk("ready_at_done", bus.load_ready_o, 1);
        chk("busy_at_done", bus.busy_o, 0);
        chk("rx_data", bus.rx_data_o, r);
        if (!b2b) begin
            tick();
            chk("done_one_cycle", bus.done_o, 0);
            chk("rx_held", bus.rx_data_o, r);
            chk("serial_idle_after", bus.serial_o, 1);
        end
    endtask

    initial begin
        bus.data_i       = 8'hFF;
        bus.len_i        = CW'(8);
        bus.msb_first_i  = 1'b0;
        bus.load_valid_i = 1'b1;
        bus.shift_i      = 1'b0;
        bus.serial_i     = 1'b1;

        // Reset held two cycles with a load request pending.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_serial", bus.serial_o, 1);
            chk("rst_ready", bus.load_ready_o, 1);
            chk("rst_busy", bus.busy_o, 0);
            chk("rst_done", bus.done_o, 0);
            chk("rst_rx", bus.rx_data_o, 0);
        end
        rst = 1'b0;
        bus.load_valid_i = 1'b0;
        tick();
        chk("post_rst_busy", bus.busy_o, 0);

        // Strobe in IDLE is ignored.
        bus.shift_i = 1'b1;
        tick();
        bus.shift_i = 1'b0;
        chk("idle_shift_busy", bus.busy_o, 0);
        chk("idle_shift_serial", bus.serial_o, 1);
        chk("idle_shift_done", bus.done_o, 0);

        // data, len, msb, serial_i word, loopback, gap, noise, shift@load, abort_at, b2b
        run_xfer(8'hA5, 8,  1'b0, 8'h5A, 1'b0, 3, 1'b0, 1'b0, -1, 1'b1);
        run_xfer(8'h3C, 8,  1'b1, 8'h00, 1'b1, 1, 1'b0, 1'b0, -1, 1'b0);
        run_xfer(8'hFF, 5,  1'b0, 8'h0D, 1'b0, 1, 1'b0, 1'b0, -1, 1'b0);
        run_xfer(8'h96, 0,  1'b0, 8'hC3, 1'b0, 1, 1'b0, 1'b0, -1, 1'b0);
        run_xfer(8'hFE, 1,  1'b1, 8'h01, 1'b0, 1, 1'b0, 1'b0, -1, 1'b0);
        run_xfer(8'hC3, 12, 1'b1, 8'h1E, 1'b0, 1, 1'b0, 1'b0, -1, 1'b0);
        run_xfer(8'h81, 8,  1'b1, 8'h3F, 1'b0, 2, 1'b1, 1'b0, -1, 1'b0);
        run_xfer(8'h5A, 8,  1'b0, 8'hF0, 1'b0, 1, 1'b0, 1'b1, -1, 1'b0);
        run_xfer(8'hE7, 8,  1'b0, 8'hFF, 1'b0, 1, 1'b0, 1'b0,  3, 1'b0);
        run_xfer(8'h6B, 6,  1'b1, 8'h2A, 1'b0, 1, 1'b0, 1'b0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
